// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//
// Loads a new set of N signed FIR coefficients one beat at a time into a
// shadow register set, then swaps the whole set into packed_coeffs in a
// single clock edge so the downstream filter never sees a half-written set.
//
// Ports
//   clk           : clock, all logic on the rising edge
//   rst           : synchronous, active-high reset
//   start         : begins (or restarts) a load at tap 0
//   coeff_in      : coefficient beat
//   coeff_valid   : coeff_in is valid
//   coeff_ready   : a beat is accepted this cycle when coeff_valid is also high
//   packed_coeffs : active coefficient set, tap t at [COEFF_WIDTH*t +: COEFF_WIDTH]
//   tap_index     : index of the next tap to be written
//   busy          : a load (or its commit) is in progress
//   commit        : one-cycle pulse coincident with a new packed_coeffs value
module fir_coeff_loader #(
    parameter int N           = 4,
    parameter int COEFF_WIDTH = 8,
    parameter logic [N*COEFF_WIDTH-1:0] DEFAULT_COEFFS = (N*COEFF_WIDTH)'(1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [COEFF_WIDTH-1:0]     coeff_in,
    input  logic                       coeff_valid,
    output logic                       coeff_ready,
    output logic [N*COEFF_WIDTH-1:0]   packed_coeffs,
    output logic [$clog2(N)-1:0]       tap_index,
    output logic                       busy,
    output logic                       commit
);

    localparam int                 TAP_W    = $clog2(N);
    localparam logic [TAP_W-1:0]   LAST_TAP = TAP_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       accept;
    logic                       last_beat;
    logic [N*COEFF_WIDTH-1:0]   shadow;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. A start pulse in LOAD blocks the beat
    // of that cycle so the restart lands cleanly on tap 0.
    always_comb begin
        state_next  = state;
        coeff_ready = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        last_beat   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy        = 1'b1;
                coeff_ready = !start;
                accept      = coeff_valid && !start;
                last_beat   = accept && (tap_index == LAST_TAP);
                if (last_beat) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                state_next = start ? LOAD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shadow write, tap counter and atomic swap into the active set
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_index     <= '0;
            shadow        <= DEFAULT_COEFFS;
            packed_coeffs <= DEFAULT_COEFFS;
            commit        <= 1'b0;
        end else begin
            commit <= (state == COMMIT);

            if (state == COMMIT) begin
                packed_coeffs <= shadow;
            end

            if (start) begin
                tap_index <= '0;
            end else if (accept) begin
                tap_index <= last_beat ? '0 : tap_index + TAP_W'(1);
            end

            // Stale entries from an aborted load stay until overwritten.
            if (accept) begin
                shadow[COEFF_WIDTH*int'(tap_index) +: COEFF_WIDTH] <= coeff_in;
            end
        end
    end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter N, default 4: number of FIR taps, which matches the tap count of the downstream filter; legal values are 2 or more.
REQ-002 SHALL have parameter COEFF_WIDTH, default 8: width of one signed coefficient.
REQ-003 SHALL have parameter DEFAULT_COEFFS, N*COEFF_WIDTH bits, default 1 (tap 0 = 1, other taps = 0, i.e. passthrough): value of packed_coeffs after reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: pulse that begins, or restarts, a coefficient load at tap index 0.
REQ-007 SHALL have port coeff_in, input, COEFF_WIDTH bits: the coefficient beat.
REQ-008 SHALL have port coeff_valid, input, 1 bit: coeff_in is valid.
REQ-009 SHALL have port coeff_ready, output, 1 bit: the loader accepts a beat this cycle.
REQ-010 SHALL have port packed_coeffs, output, N*COEFF_WIDTH bits: the active coefficient set; tap t occupies bits [COEFF_WIDTH*t +: COEFF_WIDTH].
REQ-011 SHALL have port tap_index, output, clog2(N) bits (minimum 1): the index of the next tap to be written.
REQ-012 SHALL have port busy, output, 1 bit: high while a load is in progress.
REQ-013 SHALL have port commit, output, 1 bit: one-cycle pulse coincident with a new packed_coeffs value.

Function
REQ-014 SHALL implement three states: IDLE, LOAD and COMMIT.
REQ-015 SHALL, in IDLE, drive coeff_ready=0 and ignore coeff_valid; start=1 moves the block to LOAD with tap_index=0.
REQ-016 SHALL drive coeff_ready = (state==LOAD) && !start, combinationally.
REQ-017 SHALL treat a beat as accepted only when coeff_valid && coeff_ready; on acceptance it writes coeff_in to shadow[tap_index] and increments tap_index.
REQ-018 SHALL let gaps (coeff_valid=0) in LOAD stall the load indefinitely, with no timeout.
REQ-019 SHALL, when the beat at tap_index==N-1 is accepted, move to COMMIT and wrap tap_index to 0.
REQ-020 SHALL, in COMMIT, hold coeff_ready=0; at the edge that ends COMMIT, load packed_coeffs from the shadow register set, register commit=1, and move to IDLE.
REQ-021 SHALL make the new packed_coeffs and commit=1 visible 2 cycles after the cycle in which the last beat is accepted.
REQ-022 SHALL leave packed_coeffs unchanged at all times other than the REQ-020 edge, so that a partial load never reaches the filter.
REQ-023 SHALL, on start=1 in LOAD, restart the load: tap_index goes to 0, no beat is accepted that cycle, and stale shadow entries are retained until they are overwritten.
REQ-024 SHALL, on start=1 in COMMIT, still complete the commit and then enter LOAD with tap_index=0 instead of IDLE.
REQ-025 SHALL drive busy=1 in LOAD and COMMIT, and 0 in IDLE.
REQ-026 SHALL keep commit high for exactly one cycle per completed load.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=IDLE, tap_index=0, busy=0, commit=0, coeff_ready=0, packed_coeffs=DEFAULT_COEFFS and shadow=DEFAULT_COEFFS.
REQ-028 SHALL let rst take priority over start and over beats; a reset in mid-load discards the partial load and does not commit it.

Verification (N=4, COEFF_WIDTH=8)
REQ-029 SHALL cover reset: after reset, packed_coeffs=0x00000001, busy=0, commit=0 and coeff_ready=0.
REQ-030 SHALL cover a back-to-back load: start, then beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> 2 cycles after the 0x44 beat, packed_coeffs=0x44332211 with commit=1 for one cycle, then busy=0.
REQ-031 SHALL cover backpressure and gaps: the same beats with 3 idle cycles between beats -> identical result; no beat is accepted while coeff_valid=0.
REQ-032 SHALL cover a restart: start, beats 0xAA and 0xBB, start, then 0x01, 0x02, 0x03, 0x04 -> packed_coeffs=0x04030201 and exactly one commit pulse.
REQ-033 SHALL cover reset mid-load: start, beats 0x55 and 0x66, rst -> packed_coeffs stays 0x00000001 and no commit pulse occurs.
REQ-034 SHALL cover beats in IDLE: coeff_valid=1 with 0x7F and no start -> coeff_ready=0, tap_index=0 and packed_coeffs unchanged.
